cpu0_mem_ctrl: RTL

- Parametrised, clocked successor to the cpu0 behavioural memory: a byte-addressable big-endian RAM behind a request/ready handshake with configurable wait states.
- Adds range and alignment error reporting.
- Adds a memory-mapped console port. Writes to that port are buffered in a byte FIFO and drained through a valid/ready stream.
- Sits between the cpu0 core (mar/mdr/m_en/m_rw/m_size) and the testbench console.

---
 rtl/cpu0_mem_ctrl.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/cpu0_mem_ctrl.sv
// cpu0_mem_ctrl: clocked byte-addressable big-endian RAM for the cpu0 core.
// A request is accepted in IDLE, optionally delayed by WAIT_CYCLES, then
// performed in ACCESS with alignment and range checking. Writes to IOADDR
// feed a byte FIFO that drains through a valid/ready console stream, and
// reads of IOADDR return the number of free FIFO entries.
//
// Ports:
//   clock    - system clock, rising edge
//   reset    - asynchronous active-low reset
//   en       - request strobe, sampled only in IDLE
//   rw       - 1 = read, 0 = write
//   m_size   - 00 byte, 01 int16, 10 int24, 11 int32
//   abus     - byte address
//   dbus_in  - write data, right-justified
//   dbus_out - read data, zero-extended, big-endian
//   ready    - one-cycle completion pulse
//   err      - request rejected (valid with ready)
//   io_valid - console FIFO head valid
//   io_data  - console FIFO head byte
//   io_ready - console consumer accepts the head byte
module cpu0_mem_ctrl #(
    parameter int unsigned MEMSIZE     = 'h80000,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned IOADDR      = 'h80000,
    parameter int unsigned IO_DEPTH    = 4,
    parameter string       INIT_FILE   = "cpu0s.hex"
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic        rw,
    input  logic [1:0]  m_size,
    input  logic [31:0] abus,
    input  logic [31:0] dbus_in,
    output logic [31:0] dbus_out,
    output logic        ready,
    output logic        err,
    output logic        io_valid,
    output logic [7:0]  io_data,
    input  logic        io_ready
);

    localparam int AW = $clog2(MEMSIZE);
    localparam int PW = $clog2(IO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [3:0] WAIT_LAST = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_IOPUSH, ST_DONE} state_t;

    state_t        state_r;
    logic [3:0]    cnt_r;
    logic          rw_r;
    logic [1:0]    size_r;
    logic [31:0]   addr_r;
    logic [31:0]   wdata_r;
    logic [3:0]    pend_r;
    logic          err_r;
    logic [31:0]   rdata_r;

    logic [7:0]    mem_r [MEMSIZE];
    logic [7:0]    fifo_r [IO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    logic [2:0]    bytes_s;
    logic          is_io_s;
    logic          misal_s;
    logic          range_s;
    logic          ok_s;
    logic          mem_we_s;
    logic [31:0]   rd_s;
    logic [31:0]   wal_s;
    logic [3:0]    io_mask_s;
    logic [3:0]    sel_s;
    logic [7:0]    push_byte_s;
    logic          push_s;
    logic          pop_s;
    logic          fifo_full_s;
    logic [CW-1:0] free_s;

    // Memory image initialisation: every byte defaults to 8'hFF.
    initial begin
        for (int i = 0; i < int'(MEMSIZE); i++) begin
            mem_r[i] = 8'hFF;
        end
    end

    // Request decode: size, IO hit, alignment and range checks on the latched request.
    always_comb begin
        bytes_s     = {1'b0, size_r} + 3'd1;
        is_io_s     = (addr_r == IOADDR);
        misal_s     = ((size_r == 2'b01) && addr_r[0]) ||
                      ((size_r == 2'b11) && (addr_r[1:0] != 2'b00));
        range_s     = ({1'b0, addr_r} + {30'd0, bytes_s}) > 33'(MEMSIZE);
        ok_s        = !is_io_s && !misal_s && !range_s;
        mem_we_s    = (state_r == ST_ACCESS) && !rw_r && ok_s;
        // Shift the right-justified data so the first byte to store sits in [31:24].
        wal_s       = wdata_r << {(3'd4 - bytes_s), 3'b000};
        fifo_full_s = (count_r == CW'(IO_DEPTH));
        free_s      = CW'(IO_DEPTH) - count_r;
        pop_s       = io_valid && io_ready;
    end

    // Big-endian read assembly and console byte selection.
    always_comb begin
        rd_s        = 32'h0000_0000;
        io_mask_s   = 4'b0000;
        sel_s       = 4'b0000;
        push_byte_s = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < bytes_s) begin
                rd_s         = {rd_s[23:0], mem_r[addr_r[AW-1:0] + AW'(i)]};
                io_mask_s[i] = (wdata_r[8*i +: 8] != 8'h00);
            end else begin
                rd_s         = rd_s;
            end
        end
        // Descending scan so the lowest pending byte wins.
        for (int i = 3; i >= 0; i--) begin
            if (pend_r[i]) begin
                sel_s       = 4'b0001 << i;
                push_byte_s = wdata_r[8*i +: 8];
            end else begin
                sel_s       = sel_s;
            end
        end
        // A push may proceed into a full FIFO when the head is popped the same cycle.
        push_s = (state_r == ST_IOPUSH) && (pend_r != 4'b0000) && (!fifo_full_s || pop_s);
    end

    // RAM write port: stores the low bytes of the request MSB-first.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < bytes_s) begin
                    mem_r[addr_r[AW-1:0] + AW'(i)] <= wal_s[8*(3-i) +: 8];
                end
            end
        end
    end

    // Transaction FSM with registered ready/err/dbus_out.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            rw_r     <= 1'b1;
            size_r   <= 2'b00;
            addr_r   <= 32'h0000_0000;
            wdata_r  <= 32'h0000_0000;
            pend_r   <= 4'b0000;
            err_r    <= 1'b0;
            rdata_r  <= 32'h0000_0000;
            dbus_out <= 32'h0000_0000;
            ready    <= 1'b0;
            err      <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (en) begin
                        rw_r    <= rw;
                        size_r  <= m_size;
                        addr_r  <= abus;
                        wdata_r <= dbus_in;
                        cnt_r   <= 4'd0;
                        state_r <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == WAIT_LAST) begin
                        state_r <= ST_ACCESS;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                ST_ACCESS: begin
                    err_r   <= 1'b0;
                    rdata_r <= 32'h0000_0000;
                    if (is_io_s) begin
                        if (rw_r) begin
                            rdata_r <= 32'(free_s);
                            state_r <= ST_DONE;
                        end else begin
                            // All-zero console writes complete without entering IOPUSH.
                            pend_r  <= io_mask_s;
                            state_r <= (io_mask_s == 4'b0000) ? ST_DONE : ST_IOPUSH;
                        end
                    end else if (!ok_s) begin
                        err_r   <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        if (rw_r) begin
                            rdata_r <= rd_s;
                        end
                        state_r <= ST_DONE;
                    end
                end
                ST_IOPUSH: begin
                    if (push_s) begin
                        pend_r <= pend_r & ~sel_s;
                        if ((pend_r & ~sel_s) == 4'b0000) begin
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    ready <= 1'b1;
                    err   <= err_r;
                    // Successful writes leave the last read value visible.
                    if (rw_r || err_r) begin
                        dbus_out <= rdata_r;
                    end
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Console FIFO: pointers wrap naturally, the count separates full from empty.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < int'(IO_DEPTH); i++) begin
                fifo_r[i] <= 8'h00;
            end
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= push_byte_s;
                wr_ptr_r         <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign io_valid = (count_r != '0);
    assign io_data  = fifo_r[rd_ptr_r];

endmodule
